conv_window_gen: RTL and testbench

Streaming sliding-window generator directly upstream of conv2. Accepts a raster-scan pixel stream of one SIZE x SIZE signed image. Emits every valid SIZEKer x SIZEKer window ("valid" convolution, no padding) with a valid/ready handshake. Replaces the full-frame array load with SIZEKer-1 row buffers plus a window shift register.

---
 rtl/conv_window_gen_pkg.sv | 21 ++
 rtl/conv_window_gen_if.sv | 28 ++
 rtl/conv_window_gen_line_buffer.sv | 42 ++++
 rtl/conv_window_gen.sv | 179 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared types for the streaming window generator: package conv_pkg holds the default pixel width,
// the pixel type, the FSM state enum and the window slice-index helper.
package conv_pkg;

    localparam int WIDTH_BIT_DEF = 8;

    typedef logic signed [WIDTH_BIT_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } wg_state_t;

    // Slice index of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle of conv_window_gen.
// The master modport is the upstream/downstream side; the slave modport is the generator itself.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = WIDTH_BIT_DEF
);
    logic signed [WIDTH_BIT-1:0]           pix_in;
    logic                                  pix_valid;
    logic                                  pix_ready;
    logic [SIZEKer*SIZEKer*WIDTH_BIT-1:0]  win_out;
    logic                                  win_valid;
    logic                                  win_ready;
    logic                                  win_last;
    logic                                  frame_done;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, win_last, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, win_last, frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// conv_line_buffer: DEPTH-deep single-row delay on a block-RAM ring, advanced only on pixel accept.
// dout always presents the sample written DEPTH accepts earlier (pre-fetched read register).
module conv_line_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] dout_q;

    always_comb begin
        ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end

    always_ff @(posedge clock) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

    // Read the slot that becomes the oldest after this write, so dout is valid before the next accept.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ptr_q  <= '0;
            dout_q <= '0;
        end else if (en) begin
            ptr_q  <= ptr_d;
            dout_q <= mem[ptr_d];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming SIZEKer x SIZEKer valid-window generator over a SIZE x SIZE raster frame.
// Optional CONV_WINGEN_STALL_CNT_EN adds a saturating per-frame backpressure cycle counter.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int SIZE      = 512,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = WIDTH_BIT_DEF
) (
    input  logic             clock,
    input  logic             nreset,
    conv_window_gen_if.slave bus
`ifdef CONV_WINGEN_STALL_CNT_EN
    , output logic [15:0]    stall_cnt
`endif
);
    localparam int CW = $clog2(SIZE);
    localparam int K  = SIZEKer;
    localparam int WB = WIDTH_BIT;
    localparam logic [CW-1:0] KM1  = CW'(K - 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    wg_state_t           state_q, state_d;
    logic [CW-1:0]       row_q, row_d, col_q, col_d;
    logic                alive_q;
    logic [K*K*WB-1:0]   sr_q, sr_d;
    logic [K*K*WB-1:0]   win_q, win_d;
    logic                win_valid_q, win_valid_d;
    logic                win_last_q, win_last_d;
    logic                frame_done_q, frame_done_d;

    logic                pix_ready, accept, handshake, produce;
    logic [WB-1:0]       lb_out [K-1];
    logic [WB-1:0]       tap [K];

    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [WB-1:0] lb_din;
            if (gi == 0) begin : g_head
                assign lb_din = bus.pix_in;
            end else begin : g_chain
                assign lb_din = lb_out[gi-1];
            end
            conv_line_buffer #(.DEPTH(SIZE), .WIDTH(WB)) u_lb (
                .clock (clock),
                .nreset(nreset),
                .en    (accept),
                .din   (lb_din),
                .dout  (lb_out[gi])
            );
        end
        // Row r of the window is fed from the buffer that is K-1-r rows behind the live pixel.
        for (gi = 0; gi < K; gi++) begin : g_tap
            if (gi == K - 1) begin : g_live
                assign tap[gi] = bus.pix_in;
            end else begin : g_delayed
                assign tap[gi] = lb_out[K-2-gi];
            end
        end
    endgenerate

    // Holding off while the last window is pending keeps the next frame out until DONE has passed.
    always_comb begin
        pix_ready = alive_q && (state_q != DONE) && !win_last_q && (!win_valid_q || bus.win_ready);
        accept    = bus.pix_valid && pix_ready;
        handshake = win_valid_q && bus.win_ready;
        produce   = accept && (row_q >= KM1) && (col_q >= KM1);
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        sr_d         = sr_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;

        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c < K - 1) begin
                        sr_d[win_idx(r, c, K)*WB +: WB] = sr_q[win_idx(r, c + 1, K)*WB +: WB];
                    end else begin
                        sr_d[win_idx(r, c, K)*WB +: WB] = tap[r];
                    end
                end
            end
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (produce) begin
            win_d       = sr_d;
            win_valid_d = 1'b1;
            win_last_d  = (row_q == LAST) && (col_q == LAST);
        end else if (handshake) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: if (accept) state_d = (row_d >= KM1) ? RUN : FILL;
            FILL: if (accept && (row_d >= KM1)) state_d = RUN;
            RUN: begin
                if (handshake && win_last_q) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            alive_q      <= 1'b0;
            sr_q         <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            alive_q      <= 1'b1;
            sr_q         <= sr_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_out    = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;

`ifdef CONV_WINGEN_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept && (state_q == IDLE)) begin
            stall_cnt_d = '0;
        end else if (win_valid_q && !bus.win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen (SIZE=5, SIZEKer=3, pixel value = row*5+col).
module tb_conv_window_gen;

    localparam int SIZE = 5;
    localparam int K    = 3;
    localparam int WB   = 8;
    localparam int NWIN = (SIZE - K + 1) * (SIZE - K + 1);
    localparam int EW   = K * K * WB + 1;

    logic clock  = 1'b0;
    logic nreset = 1'b1;
    always #5 clock = ~clock;

    conv_window_gen_if #(.SIZEKer(K), .WIDTH_BIT(WB)) bus ();

`ifdef CONV_WINGEN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_window_gen #(.SIZE(SIZE), .SIZEKer(K), .WIDTH_BIT(WB)) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus)
`ifdef CONV_WINGEN_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] exp_win(input int br, input int bc);
        logic [EW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K+c)*WB +: WB] = WB'((br - K + 1 + r) * SIZE + (bc - K + 1 + c));
            end
        end
        w[EW-1] = (br == SIZE - 1) && (bc == SIZE - 1);
        return w;
    endfunction

    logic [EW-1:0] sb [$];
    logic [EW-1:0] exp_e;
    int  mode = 0;
    int  hs_cnt = 0;
    int  mon_pix = 0;
    int  mon_r, mon_c;
    bit  prev_prod = 0, prev_last_hs = 0, prev_done = 0;
    int  bp_used = 0;

    // Monitor: push expected windows on accept, pop and compare on handshake.
    always @(negedge clock) begin
        if (!nreset) begin
            sb.delete();
            hs_cnt = 0; mon_pix = 0;
            prev_prod = 0; prev_last_hs = 0; prev_done = 0;
        end else begin
            if (prev_prod) check_eq("latency", bus.win_valid, 1'b1);
            if (bus.frame_done || prev_last_hs) check_eq("frame_done", bus.frame_done, prev_last_hs);
            if (prev_done) check_eq("done_pulse", bus.frame_done, 1'b0);
            if (bus.frame_done) begin
                check_eq("done_stall", bus.pix_ready, 1'b0);
                check_eq("win_count", hs_cnt, NWIN);
                check_eq("sb_empty", sb.size(), 0);
                hs_cnt = 0;
                mon_pix = 0;
            end
            if (bus.win_valid && !bus.win_ready) begin
                check_eq("stall_ready", bus.pix_ready, 1'b0);
                if (sb.size() > 0) check_eq("hold_win", {bus.win_last, bus.win_out}, sb[0]);
            end
            prev_last_hs = 0;
            if (bus.win_valid && bus.win_ready) begin
                check_eq("sb_avail", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp_e = sb.pop_front();
                    check_eq("window", {bus.win_last, bus.win_out}, exp_e);
                    prev_last_hs = exp_e[EW-1];
                    hs_cnt++;
                    $display("win %0d last=%0b data=%0h", hs_cnt, bus.win_last, bus.win_out);
                end
            end
            prev_prod = 0;
            if (bus.pix_valid && bus.pix_ready) begin
                mon_r = mon_pix / SIZE;
                mon_c = mon_pix % SIZE;
                if (mon_r >= K - 1 && mon_c >= K - 1) begin
                    sb.push_back(exp_win(mon_r, mon_c));
                    prev_prod = 1;
                end
                mon_pix++;
            end
            prev_done = bus.frame_done;
        end
    end

    // Downstream ready: always, stall the second window for 4 cycles, or random.
    always @(posedge clock) begin
        #1;
        if (hs_cnt == 0) bp_used = 0;
        case (mode)
            1: begin
                if (bus.win_valid && hs_cnt == 1 && bp_used < 4) begin
                    bus.win_ready = 1'b0;
                    bp_used++;
                end else begin
                    bus.win_ready = 1'b1;
                end
            end
            2:       bus.win_ready = 1'($urandom_range(0, 1));
            default: bus.win_ready = 1'b1;
        endcase
    end

    task automatic send_pixels(input int first, input int last, input bit gaps);
        int i = first;
        int guard = 0;
        bit acc;
        while (i <= last && guard < 2000) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_in    = WB'(i);
            end
            @(negedge clock);
            acc = bus.pix_valid && bus.pix_ready;
            @(posedge clock);
            #1;
            if (acc) i++;
        end
        bus.pix_valid = 1'b0;
        check_eq("send_timeout", i > last, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (bus.frame_done) break;
        end
        check_eq("done_timeout", bus.frame_done, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, bus.win_valid, 1'b0);
        check_eq({tag, "_last"}, bus.win_last, 1'b0);
        check_eq({tag, "_done"}, bus.frame_done, 1'b0);
        check_eq({tag, "_win"}, bus.win_out, '0);
        check_eq({tag, "_ready"}, bus.pix_ready, 1'b0);
`ifdef CONV_WINGEN_STALL_CNT_EN
        check_eq({tag, "_stall"}, stall_cnt, 16'd0);
`endif
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        #1 nreset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        nreset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("ready_after_reset", bus.pix_ready, 1'b1);

        $display("frame 1: continuous, followed back-to-back by frame 2");
        mode = 0;
        send_pixels(0, SIZE*SIZE-1, 0);
        send_pixels(0, SIZE*SIZE-1, 0);
        wait_done();

        $display("frame 3: backpressure on second window");
        mode = 1;
        send_pixels(0, SIZE*SIZE-1, 0);
        wait_done();
`ifdef CONV_WINGEN_STALL_CNT_EN
        check_eq("stall_cnt_end", stall_cnt, 16'd4);
`endif

        $display("frame 4: random gaps and random ready");
        mode = 2;
        send_pixels(0, 0, 0);
`ifdef CONV_WINGEN_STALL_CNT_EN
        check_eq("stall_cnt_clear", stall_cnt, 16'd0);
`endif
        send_pixels(1, SIZE*SIZE-1, 1);
        wait_done();

        $display("frame 5: reset after pixel 17, then fresh frame");
        mode = 0;
        send_pixels(0, 17, 0);
        nreset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_pixels(0, SIZE*SIZE-1, 0);
        wait_done();

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
